// File: rtl/oscilo_pkg.sv
// Shared constants and types for the oscilloscope capture/read-back path.
package oscilo_pkg;

    localparam int unsigned CLK_HZ_DEFAULT   = 50_000_000;
    localparam int unsigned BAUD_DEFAULT     = 115_200;
    localparam int unsigned BAUD_DIV_DEFAULT = CLK_HZ_DEFAULT / BAUD_DEFAULT;

    // Top-level state watcher code that launches the read-back.
    localparam logic [7:0] ST_SAMPLE_READ = 8'h22;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StWaitH,
        StFetch,
        StWaitS,
        StDone
    } sample_reader_state_t;

endpackage

// File: rtl/sample_reader_if.sv
// Async-read sample memory port: the reader drives address/enable, memory returns data.
interface sample_reader_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
);

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_oe;
    logic [DATA_WIDTH-1:0] mem_data;

    modport master (
        output mem_addr,
        output mem_oe,
        input  mem_data
    );

    modport slave (
        input  mem_addr,
        input  mem_oe,
        output mem_data
    );

endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; one byte per tx_start, tx_busy covers start bit through stop bit.
module uart_tx
    import oscilo_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk_50mhz,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tx_busy
);

    localparam int unsigned CntW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(BAUD_DIV - 1);

    logic [CntW-1:0] baud_cnt_q;
    logic [3:0]      bit_idx_q;
    logic [9:0]      shift_q;
    logic            busy_q;

    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '1;
            busy_q     <= 1'b0;
        end else if (!busy_q) begin
            if (tx_start) begin
                shift_q    <= {1'b1, tx_data, 1'b0};
                busy_q     <= 1'b1;
                baud_cnt_q <= '0;
                bit_idx_q  <= '0;
            end
        end else if (baud_cnt_q == CntMax) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == 4'd9) begin
                busy_q <= 1'b0;
            end else begin
                bit_idx_q <= bit_idx_q + 4'd1;
                shift_q   <= {1'b1, shift_q[9:1]};
            end
        end else begin
            baud_cnt_q <= baud_cnt_q + CntW'(1);
        end
    end

    // Combinational so that reset forces the line idle without waiting for a clock.
    assign txd     = busy_q ? shift_q[0] : 1'b1;
    assign tx_busy = busy_q;

endmodule

// File: rtl/sample_reader.sv
// Streams a sync header plus every sample-memory word over UART after an activate edge.
module sample_reader
    import oscilo_pkg::*;
#(
    parameter int unsigned CLK_HZ     = CLK_HZ_DEFAULT,
    parameter int unsigned BAUD       = BAUD_DEFAULT,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic             clk_50mhz,
    input  logic             reset,
    input  logic             activate,
    output logic             done,
    output logic             busy,
    sample_reader_if.master  mem,
    output logic             txd
);

    localparam int unsigned BAUD_DIV = CLK_HZ / BAUD;

    sample_reader_state_t  state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  act_q;
    logic                  start_edge;
    logic                  tx_start;
    logic [7:0]            tx_data;
    logic                  tx_busy;
    logic [DATA_WIDTH-1:0] sample;

    assign start_edge = activate & ~act_q;
    assign sample     = mem.mem_data;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            StIdle: begin
                if (start_edge) begin
                    state_d = StHdr;
                    addr_d  = '0;
                end
            end
            StHdr:   state_d = StWaitH;
            StWaitH: if (!tx_busy) state_d = StFetch;
            StFetch: state_d = StWaitS;
            StWaitS: begin
                if (!tx_busy) begin
                    // Compare rather than rely on overflow so the address never wraps.
                    if (addr_q == '1) begin
                        state_d = StDone;
                    end else begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        state_d = StFetch;
                    end
                end
            end
            StDone: begin
                if (start_edge) begin
                    state_d = StHdr;
                    addr_d  = '0;
                end else if (!activate) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            act_q   <= activate;
        end
    end

    assign done         = (state_q == StDone);
    assign busy         = (state_q != StIdle) && (state_q != StDone);
    assign mem.mem_oe   = (state_q == StFetch);
    assign mem.mem_addr = addr_q;
    assign tx_start     = (state_q == StHdr) || (state_q == StFetch);
    assign tx_data      = (state_q == StFetch) ? sample[7:0] : HEADER;

    uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_tx (
        .clk_50mhz (clk_50mhz),
        .reset     (reset),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .txd       (txd),
        .tx_busy   (tx_busy)
    );

endmodule
